arith_unit_iter: RTL
====================

Name: arith_unit_iter

Overview:
Parametrised next-generation arithmetic unit for the ALU datapath. ADD and SUB complete in a single cycle. MUL uses an iterative shift-add engine and DIV uses a restoring divide engine, replacing the purely combinational multiply and divide paths. A Busy/OUT_VALID handshake, carry/borrow flag and divide-by-zero flag let the register-file controller sequence operations across multi-cycle latency.

Parameters:
WIDTH, 8, operand width of A and B (legal range 4..32)
ALU_FUN_WIDTH, 2, opcode width (fixed at 2)
OUT_WIDTH, 2*WIDTH, result width (derived localparam, not overridable)

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  reset, asynchronous, active-low
A  input  WIDTH  operand A, unsigned
B  input  WIDTH  operand B, unsigned
ALU_FUN  input  2  opcode: 00 ADD, 01 SUB, 10 MUL, 11 DIV
Arith_Enable  input  1  start request, sampled only when Busy=0
Arith_OUT  output  OUT_WIDTH  registered result
OUT_VALID  output  1  one-cycle pulse: result and flags are valid
Busy  output  1  multi-cycle operation in progress
Carry_Flag  output  1  ADD carry-out / SUB borrow
Div_By_Zero  output  1  last DIV had B=0

Behaviour:
- Reset (RST low, async): all outputs 0, state IDLE, iteration counter 0, internal operands 0. Asserting reset mid-operation aborts it; no OUT_VALID is produced for the aborted operation.
- FSM states: IDLE, MUL_RUN, DIV_RUN.
- Acceptance: in IDLE, Arith_Enable=1 at edge k captures A, B and ALU_FUN. Later operand changes have no effect on the accepted operation.
- ADD: at edge k+1, Arith_OUT = zero-extended {carry, A+B} in the low WIDTH+1 bits. Carry_Flag = carry. OUT_VALID = 1. Latency 1.
- SUB: at edge k+1, low WIDTH bits = (A-B) mod 2^WIDTH, bit WIDTH = borrow (A<B), upper bits 0. Carry_Flag = borrow. Latency 1.
- MUL: at edge k the FSM enters MUL_RUN and Busy=1. One partial product per cycle, WIDTH iterations. At edge k+WIDTH+1: Arith_OUT = A*B (full OUT_WIDTH), OUT_VALID=1, Busy=0, FSM returns to IDLE.
- DIV with B!=0: DIV_RUN, restoring algorithm, one quotient bit per cycle, same timing as MUL. Arith_OUT[WIDTH-1:0] = quotient, Arith_OUT[OUT_WIDTH-1:WIDTH] = remainder.
- DIV with B=0: the FSM stays in IDLE. At edge k+1: quotient field all ones, remainder field = A, Div_By_Zero=1, OUT_VALID=1. Latency 1.
- Carry_Flag is 0 for MUL and DIV. Div_By_Zero is 0 for every op except DIV with B=0.
- Flags and Arith_OUT update only on the edge that raises OUT_VALID and hold their values until the next result.
- OUT_VALID is exactly one cycle wide.
- While Busy=1, Arith_Enable is ignored. No queueing, no error.
- Back-to-back: in the cycle OUT_VALID=1 the FSM is already IDLE, so Arith_Enable=1 in that cycle is accepted.
- Iteration counter is ceil(log2(WIDTH+1)) bits, cleared on acceptance. The last iteration is detected at count WIDTH-1.

Decomposition:
- Package arith_pkg holds the opcode constants OP_ADD/OP_SUB/OP_MUL/OP_DIV, the FSM state encoding, and a function for the counter width.
- Sub-module arith_iter_core holds the shared shift register, accumulator and counter for MUL and DIV, with ports start, op, a, b, done, result.
- The top level holds the FSM, the single-cycle ADD/SUB path, divide-by-zero bypass, output registers and flags.

Test Plan (WIDTH=8):
1. ADD A=200 B=100 -> next edge Arith_OUT=0x012C, Carry_Flag=1, OUT_VALID pulses 1 cycle, Busy stays 0.
2. SUB A=5 B=10 -> Arith_OUT=0x01FB, Carry_Flag=1. Then SUB A=10 B=5 -> 0x0005, Carry_Flag=0.
3. MUL A=255 B=255 -> Busy high 9 cycles, OUT_VALID on 9th edge, Arith_OUT=0xFE01. Arith_Enable/A/B toggled mid-run are ignored and the result is unchanged.
4. DIV A=200 B=7 -> after 9 cycles Arith_OUT=0x041C (rem 4, quot 28), Div_By_Zero=0. Then an ADD is issued in the OUT_VALID cycle and is accepted.
5. DIV A=0x5A B=0 -> next edge Arith_OUT=0x5AFF, Div_By_Zero=1, Busy never rises.
6. MUL 13*11, RST pulsed low at cycle 4 -> all outputs 0 immediately, no OUT_VALID. A following ADD 1+2 gives 0x0003 with latency 1.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared opcodes, FSM encoding and sizing helper for arith_unit_iter.
// Imported by the top level and by the iterative MUL/DIV core.
package arith_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_MUL_RUN = 2'd1;
  localparam logic [1:0] S_DIV_RUN = 2'd2;

  // Counter must hold 0..WIDTH.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/arith_iter_core.sv
// Shared shift/accumulate engine: shift-add MUL and restoring DIV.
// Ports: CLK, RST, start, op, a, b -> done (1-cycle pulse), result.
module arith_iter_core
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int OW = 2 * WIDTH;
  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [OW-1:0]    acc;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]    cnt;
  logic             run;
  logic             div_q;

  logic [WIDTH:0]   msum;
  logic [OW-1:0]    mul_nxt;
  logic [WIDTH:0]   shl;
  logic [WIDTH+1:0] dd;
  logic [WIDTH-1:0] rem;
  logic [OW-1:0]    div_nxt;

  // MUL: acc = {hi, multiplier}; add b into hi when lsb set, shift right.
  // DIV: acc = {rem, dividend/quotient}; shift left, trial subtract.
  always_comb begin
    msum    = {1'b0, acc[OW-1:WIDTH]}
            + (acc[0] ? {1'b0, b_q} : '0);
    mul_nxt = {msum, acc[WIDTH-1:1]};
    shl     = {acc[OW-1:WIDTH], acc[WIDTH-1]};
    dd      = {1'b0, shl} - {2'b00, b_q};
    rem     = dd[WIDTH+1] ? shl[WIDTH-1:0]
                          : dd[WIDTH-1:0];
    div_nxt = {rem, acc[WIDTH-2:0], ~dd[WIDTH+1]};
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      acc   <= '0;
      b_q   <= '0;
      cnt   <= '0;
      run   <= 1'b0;
      div_q <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        acc   <= {{WIDTH{1'b0}}, a};
        b_q   <= b;
        div_q <= (op == OP_DIV);
        cnt   <= '0;
        run   <= 1'b1;
      end else if (run) begin
        acc <= div_q ? div_nxt : mul_nxt;
        cnt <= cnt + CW'(1);
        if (cnt == LAST) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign result = acc;

endmodule

// File: rtl/arith_unit_iter.sv
// Arithmetic unit: 1-cycle ADD/SUB/DIV-by-0, iterative MUL/DIV.
// Ports: CLK, RST, A, B, ALU_FUN, Arith_Enable -> Arith_OUT, OUT_VALID, Busy, flags.
module arith_unit_iter
  import arith_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int ALU_FUN_WIDTH = 2
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [WIDTH-1:0]         A,
  input  logic [WIDTH-1:0]         B,
  input  logic [ALU_FUN_WIDTH-1:0] ALU_FUN,
  input  logic                     Arith_Enable,
  output logic [2*WIDTH-1:0]       Arith_OUT,
  output logic                     OUT_VALID,
  output logic                     Busy,
  output logic                     Carry_Flag,
  output logic                     Div_By_Zero
);

  localparam int OUT_WIDTH = 2 * WIDTH;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       op_q;
  logic             pend;

  logic accept;
  logic dz;
  logic iter;
  logic is_mul;
  logic is_div;

  logic                 core_done;
  logic [OUT_WIDTH-1:0] core_res;

  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       diff;
  logic [OUT_WIDTH-1:0] sc_out;
  logic                 sc_c;
  logic                 sc_z;

  assign Busy   = (state != S_IDLE);
  assign accept = Arith_Enable && (state == S_IDLE);
  assign is_mul = (ALU_FUN == OP_MUL);
  assign is_div = (ALU_FUN == OP_DIV);
  assign dz     = is_div && (B == '0);
  assign iter   = accept && (is_mul || (is_div && !dz));

  arith_iter_core #(.WIDTH(WIDTH)) u_core (
    .CLK    (CLK),
    .RST    (RST),
    .start  (iter),
    .op     (ALU_FUN),
    .a      (A),
    .b      (B),
    .done   (core_done),
    .result (core_res)
  );

  // Single-cycle path from the captured operands; a MUL/DIV
  // never sets pend, so only ADD, SUB and DIV-by-0 land here.
  always_comb begin
    sum    = {1'b0, a_q} + {1'b0, b_q};
    diff   = {1'b0, a_q} - {1'b0, b_q};
    sc_out = '0;
    sc_c   = 1'b0;
    sc_z   = 1'b0;
    unique case (1'b1)
      (op_q == OP_ADD): begin
        sc_out = {{(WIDTH-1){1'b0}}, sum};
        sc_c   = sum[WIDTH];
      end
      (op_q == OP_SUB): begin
        sc_out = {{(WIDTH-1){1'b0}}, diff};
        sc_c   = diff[WIDTH];
      end
      default: begin
        sc_out = {a_q, {WIDTH{1'b1}}};
        sc_z   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= OP_ADD;
      pend        <= 1'b0;
      Arith_OUT   <= '0;
      OUT_VALID   <= 1'b0;
      Carry_Flag  <= 1'b0;
      Div_By_Zero <= 1'b0;
    end else begin
      OUT_VALID <= 1'b0;
      pend      <= accept && !iter;
      if (accept) begin
        a_q  <= A;
        b_q  <= B;
        op_q <= ALU_FUN;
        if (iter)
          state <= is_mul ? S_MUL_RUN : S_DIV_RUN;
      end
      if (pend) begin
        Arith_OUT   <= sc_out;
        Carry_Flag  <= sc_c;
        Div_By_Zero <= sc_z;
        OUT_VALID   <= 1'b1;
      end
      if (Busy && core_done) begin
        Arith_OUT   <= core_res;
        Carry_Flag  <= 1'b0;
        Div_By_Zero <= 1'b0;
        OUT_VALID   <= 1'b1;
        state       <= S_IDLE;
      end
    end
  end

endmodule
